line_buffer_3x3: RTL

- Two-line delay buffer feeding the 3x3 window stage.
- Accepts a raster pixel stream, one pixel per valid cycle.
- Once two full rows are stored, emits one vertical 3-pixel column per accepted pixel.
- Pulses done_o so the downstream window controller (its done_i) leaves IDLE and starts column assembly.

---
 rtl/line_buffer_3x3_pkg.sv | 17 +
 rtl/line_shift_fifo.sv | 34 +++
 rtl/line_buffer_3x3.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/line_buffer_3x3_pkg.sv
// Shared constants for the 3x3 window front end: state encoding and image defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package line_buffer_3x3_pkg;

  // Pixel and image defaults, shared with the window buffer blocks.
  localparam int LB_DATA_WIDTH = 8;
  localparam int LB_IMG_WIDTH  = 640;
  localparam int LB_IMG_HEIGHT = 480;

  // Line buffer FSM encoding.
  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_FILL      = 2'b01;
  localparam logic [1:0] ST_STREAM    = 2'b10;
  localparam logic [1:0] ST_FRAME_END = 2'b11;

endpackage

// File: rtl/line_shift_fifo.sv
// One image line of delay: a DEPTH-deep shift register that advances only on shift_en.
// Latency: d_oldest is the pixel shifted in DEPTH accepted shifts ago.
// Backpressure: none; shifting is gated by shift_en only.
// Ports: clk, rst (sync active-low; blocks shifting, storage not cleared),
//        shift_en, d_in (new pixel), d_oldest (oldest stored pixel).
module line_shift_fifo
  import line_buffer_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int DEPTH      = LB_IMG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_oldest
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; reset only blocks a shift so a pixel
  // presented together with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && shift_en) begin
      mem[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign d_oldest = mem[DEPTH-1];

endmodule

// File: rtl/line_buffer_3x3.sv
// Two-line delay buffer: turns a raster pixel stream into vertical 3-pixel columns.
// Latency: one cycle from the accepting edge to o_valid/o_col_*; done_o and o_frame_done registered.
// Backpressure: none; i_valid bubbles stall the pipeline, every o_valid column must be taken.
// Ports: clk, rst (sync active-low), i_valid/i_data (pixel in), o_valid/o_col_top/mid/bot
//        (column out), done_o (streaming start pulse), o_frame_done (frame end pulse), o_busy.
// Option: LINE_BUFFER_ZERO_PAD_EN zero-pads the top border so streaming starts at row 0.
module line_buffer_3x3
  import line_buffer_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int IMG_WIDTH  = LB_IMG_WIDTH,
  parameter int IMG_HEIGHT = LB_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_col_top,
  output logic [DATA_WIDTH-1:0] o_col_mid,
  output logic [DATA_WIDTH-1:0] o_col_bot,
  output logic                  done_o,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [1:0]            state;
  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic                  accept;
  logic                  emit;
  logic                  col_last;
  logic                  row_last;
  logic [DATA_WIDTH-1:0] line0_old;
  logic [DATA_WIDTH-1:0] line1_old;
  logic [DATA_WIDTH-1:0] mid_col;
  logic [DATA_WIDTH-1:0] top_col;

  // The FRAME_END cycle swallows whatever is on i_valid.
  assign accept   = i_valid && (state != ST_FRAME_END);
  assign col_last = (col_cnt == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
  assign o_busy   = (state != ST_IDLE);

  line_shift_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_line0 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .d_in     (i_data),
    .d_oldest (line0_old)
  );

  // line1 is fed from line0's oldest entry, giving a two-row delay.
  line_shift_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_line1 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .d_in     (line0_old),
    .d_oldest (line1_old)
  );

`ifdef LINE_BUFFER_ZERO_PAD_EN
  // Rows above the image do not exist: the lines hold stale data there, so force zero.
  assign emit    = accept && (state != ST_FILL);
  assign mid_col = (row_cnt == '0) ? '0 : line0_old;
  assign top_col = (row_cnt < ROW_W'(2)) ? '0 : line1_old;
`else
  assign emit    = accept && (state == ST_STREAM);
  assign mid_col = line0_old;
  assign top_col = line1_old;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      col_cnt      <= '0;
      row_cnt      <= '0;
      o_valid      <= 1'b0;
      o_col_top    <= '0;
      o_col_mid    <= '0;
      o_col_bot    <= '0;
      done_o       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= emit;
      done_o       <= 1'b0;
      o_frame_done <= 1'b0;

      if (emit) begin
        o_col_top <= top_col;
        o_col_mid <= mid_col;
        o_col_bot <= i_data;
      end

      if (accept) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
        end else begin
          col_cnt <= col_cnt + COL_W'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef LINE_BUFFER_ZERO_PAD_EN
            state  <= ST_STREAM;
            done_o <= 1'b1;
`else
            state  <= ST_FILL;
`endif
          end
        end
        ST_FILL: begin
          // End of row 1: both lines now hold real rows.
          if (accept && col_last && (row_cnt == ROW_W'(1))) begin
            state  <= ST_STREAM;
            done_o <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept && col_last && row_last) begin
            state        <= ST_FRAME_END;
            o_frame_done <= 1'b1;
          end
        end
        ST_FRAME_END: begin
          state   <= ST_IDLE;
          col_cnt <= '0;
          row_cnt <= '0;
        end
      endcase
    end
  end

endmodule
